// File: rtl/crc_dec_serial_pkg.sv
// Shared constants and types for the serial CRC codec: default widths,
// codeword length, checker FSM states and the default generator polynomial.
package crc_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int CRC_W_DEF    = 3;
  localparam int ERRCNT_W_DEF = 8;
  localparam int CW_LEN       = DATA_W_DEF + CRC_W_DEF;

  localparam logic [0:CRC_W_DEF] DEF_DIVISOR = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/crc_dec_serial_if.sv
// Serial codeword input, result output and status bundle of the CRC checker.
// slave is the checker side, master is the link/consumer side.
interface crc_dec_serial_if
  import crc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CRC_W    = CRC_W_DEF,
  parameter int ERRCNT_W = ERRCNT_W_DEF
);

  logic [0:CRC_W]        divisor;
  logic                  in_valid;
  logic                  in_sof;
  logic                  in_bit;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [0:DATA_W-1]     data_out;
  logic [0:CRC_W-1]      syndrome;
  logic                  crc_err;
  logic [ERRCNT_W-1:0]   err_cnt;
  logic                  abort_pulse;

  modport master (
    output divisor, in_valid, in_sof, in_bit, out_ready,
    input  in_ready, out_valid, data_out, syndrome, crc_err, err_cnt, abort_pulse
  );

  modport slave (
    input  divisor, in_valid, in_sof, in_bit, out_ready,
    output in_ready, out_valid, data_out, syndrome, crc_err, err_cnt, abort_pulse
  );

endinterface

// File: rtl/crc_dec_serial_lfsr_step.sv
// One bit of polynomial long division: shift b into the remainder and
// subtract (xor) the generator taps when the bit shifted out is set.
module crc_lfsr_step #(
  parameter int CRC_W = 3
) (
  input  logic [0:CRC_W-1] r_i,
  input  logic             b_i,
  input  logic [0:CRC_W-1] taps_i,
  output logic [0:CRC_W-1] r_next_o
);

  assign r_next_o = {r_i[1:CRC_W-1], b_i} ^ (r_i[0] ? taps_i : '0);

endmodule

// File: rtl/crc_dec_serial.sv
// Bit-serial CRC checker: takes an MSB-first codeword one bit per cycle and
// returns data, syndrome and error flag one cycle after the last bit, held until handshaken.
module crc_dec_serial
  import crc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CRC_W    = CRC_W_DEF,
  parameter int ERRCNT_W = ERRCNT_W_DEF
) (
  input logic             clk,
  input logic             rst,
  crc_dec_serial_if.slave bus
);

  localparam int CW_LEN_L = DATA_W + CRC_W;
  localparam int CNT_W    = $clog2(CW_LEN_L + 1);

  state_e                state_q, state_d;
  logic [0:CRC_W-1]      lfsr_q, lfsr_d;
  logic [0:DATA_W-1]     data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [0:CRC_W]        div_q, div_d;
  logic                  ovld_q, ovld_d;
  logic [0:DATA_W-1]     dout_q, dout_d;
  logic [0:CRC_W-1]      syn_q, syn_d;
  logic                  err_q, err_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;
  logic                  abort_q, abort_d;

  logic                  in_ready;
  logic                  acc;
  logic                  start;
  logic [0:CRC_W-1]      step_r;
  logic [0:CRC_W-1]      step_next;
  logic                  unused_div_msb;

  // The generator MSB is implicitly 1; only the lower taps are ever applied.
  assign unused_div_msb = div_q[0];

  assign in_ready = ~rst & (state_q != DONE);
  assign acc      = bus.in_valid & in_ready;
  assign start    = acc & bus.in_sof;

  // A new frame divides from an all-zero remainder, so the tap source is moot.
  assign step_r = start ? '0 : lfsr_q;

  crc_lfsr_step #(.CRC_W(CRC_W)) u_step (
    .r_i      (step_r),
    .b_i      (bus.in_bit),
    .taps_i   (div_q[1:CRC_W]),
    .r_next_o (step_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      div_q    <= '0;
      ovld_q   <= 1'b0;
      dout_q   <= '0;
      syn_q    <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ovld_q   <= ovld_d;
      dout_q   <= dout_d;
      syn_q    <= syn_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    ovld_d   = ovld_q;
    dout_d   = dout_q;
    syn_d    = syn_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    abort_d  = 1'b0;

    if (start) begin
      // Start of frame wins in SHIFT too: the partial frame is dropped.
      div_d              = bus.divisor;
      lfsr_d             = step_next;
      data_d             = '0;
      data_d[DATA_W-1]   = bus.in_bit;
      cnt_d              = CNT_W'(1);
      abort_d            = (state_q == SHIFT);
      state_d            = SHIFT;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        SHIFT: begin
          if (acc) begin
            lfsr_d = step_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q < CNT_W'(DATA_W)) begin
              data_d = {data_q[1:DATA_W-1], bus.in_bit};
            end
            if (cnt_q == CNT_W'(CW_LEN_L - 1)) begin
              syn_d   = step_next;
              dout_d  = data_q;
              err_d   = |step_next;
              ovld_d  = 1'b1;
              cnt_d   = '0;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (ovld_q && bus.out_ready) begin
            ovld_d  = 1'b0;
            state_d = IDLE;
            if (err_q && !(&errcnt_q)) begin
              errcnt_d = errcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = ovld_q;
  assign bus.data_out    = dout_q;
  assign bus.syndrome    = syn_q;
  assign bus.crc_err     = err_q;
  assign bus.err_cnt     = errcnt_q;
  assign bus.abort_pulse = abort_q;

endmodule

// File: tb/tb_crc_dec_serial.sv
// Directed bench for crc_dec_serial: clean/errored frames, backpressure,
// abort, gaps, asynchronous reset and error-counter saturation.
module tb_crc_dec_serial;
  import crc_pkg::*;

  logic clk;
  logic rst;

  crc_dec_serial_if bus ();

  crc_dec_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int ov_cnt;
  int ab_cnt;

  localparam logic [10:0] CW_CLEAN = 11'b110_1001_1011;
  localparam logic [10:0] CW_ERR0  = 11'b010_1001_1011;
  localparam logic [10:0] CW_ERR10 = 11'b110_1001_1010;

  // Sample at each negedge before driving the next bit; count out_valid/abort_pulse.
  task automatic drive_frame(input logic [10:0] cw, input bit gaps);
    int g;
    ov_cnt = 0;
    ab_cnt = 0;
    for (int i = 0; i < CW_LEN; i++) begin
      if (gaps) begin
        g = $urandom_range(2, 0);
        repeat (g) begin
          @(negedge clk);
          ov_cnt += int'(bus.out_valid);
          ab_cnt += int'(bus.abort_pulse);
          bus.in_valid = 1'b0;
          bus.in_sof   = 1'b0;
        end
      end
      @(negedge clk);
      ov_cnt += int'(bus.out_valid);
      ab_cnt += int'(bus.abort_pulse);
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0);
      bus.in_bit   = cw[CW_LEN-1-i];
    end
    @(negedge clk);
    ov_cnt += int'(bus.out_valid);
    ab_cnt += int'(bus.abort_pulse);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.divisor   = DEF_DIVISOR;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%b exp=0", bus.data_out); end
    n_checks++; if (bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL reset_syndrome got=%b exp=000", bus.syndrome); end
    n_checks++; if (bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_crc_err got=%b exp=0", bus.crc_err); end
    n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got=%0d exp=0", bus.err_cnt); end
    n_checks++; if (bus.abort_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_abort got=%b exp=0", bus.abort_pulse); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_clean();
    drive_frame(CW_CLEAN, 1'b0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_out_valid got=%b exp=1", bus.out_valid); end
    n_checks++; if (ov_cnt != 1) begin n_fail++; $display("FAIL clean_valid_count got=%0d exp=1", ov_cnt); end
    n_checks++; if (bus.data_out !== 8'b11010011) begin n_fail++; $display("FAIL clean_data got=%b exp=11010011", bus.data_out); end
    n_checks++; if (bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL clean_syndrome got=%b exp=000", bus.syndrome); end
    n_checks++; if (bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL clean_crc_err got=%b exp=0", bus.crc_err); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clean_done_in_ready got=%b exp=0", bus.in_ready); end
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_clear got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL clean_back_idle got=%b exp=1", bus.in_ready); end
    n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL clean_err_cnt got=%0d exp=0", bus.err_cnt); end
  endtask

  task automatic test_errors();
    drive_frame(CW_ERR0, 1'b0);
    n_checks++; if (bus.syndrome !== 3'b011) begin n_fail++; $display("FAIL err0_syndrome got=%b exp=011", bus.syndrome); end
    n_checks++; if (bus.crc_err !== 1'b1) begin n_fail++; $display("FAIL err0_crc_err got=%b exp=1", bus.crc_err); end
    n_checks++; if (bus.data_out !== 8'b01010011) begin n_fail++; $display("FAIL err0_data got=%b exp=01010011", bus.data_out); end
    @(negedge clk);
    n_checks++; if (bus.err_cnt !== 8'd1) begin n_fail++; $display("FAIL err0_err_cnt got=%0d exp=1", bus.err_cnt); end
    drive_frame(CW_ERR10, 1'b0);
    n_checks++; if (bus.syndrome !== 3'b001) begin n_fail++; $display("FAIL err10_syndrome got=%b exp=001", bus.syndrome); end
    n_checks++; if (bus.data_out !== 8'b11010011) begin n_fail++; $display("FAIL err10_data got=%b exp=11010011", bus.data_out); end
    n_checks++; if (bus.crc_err !== 1'b1) begin n_fail++; $display("FAIL err10_crc_err got=%b exp=1", bus.crc_err); end
    @(negedge clk);
    n_checks++; if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL err10_err_cnt got=%0d exp=2", bus.err_cnt); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive_frame(CW_CLEAN, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_sof   = 1'b1;
      bus.in_bit   = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      n_checks++; if (bus.data_out !== 8'b11010011 || bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL bp_stable cyc=%0d got=%b/%b exp=11010011/000", c, bus.data_out, bus.syndrome); end
    end
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b exp=0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle got=%b exp=1", bus.in_ready); end
    // A frame accepted during DONE would turn this sof into an abort.
    drive_frame(CW_CLEAN, 1'b0);
    n_checks++; if (ab_cnt != 0) begin n_fail++; $display("FAIL bp_no_accept abort_count=%0d exp=0", ab_cnt); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0);
      bus.in_bit   = CW_ERR0[CW_LEN-1-i];
    end
    drive_frame(CW_CLEAN, 1'b0);
    n_checks++; if (ab_cnt != 1) begin n_fail++; $display("FAIL abort_pulse_count got=%0d exp=1", ab_cnt); end
    n_checks++; if (ov_cnt != 1) begin n_fail++; $display("FAIL abort_valid_count got=%0d exp=1", ov_cnt); end
    n_checks++; if (bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL abort_syndrome got=%b exp=000", bus.syndrome); end
    n_checks++; if (bus.data_out !== 8'b11010011) begin n_fail++; $display("FAIL abort_data got=%b exp=11010011", bus.data_out); end
    @(negedge clk);
    n_checks++; if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_err_cnt got=%0d exp=2", bus.err_cnt); end
  endtask

  task automatic test_gaps();
    for (int k = 0; k < 3; k++) begin
      drive_frame(CW_CLEAN, 1'b1);
      n_checks++; if (bus.out_valid !== 1'b1 || ov_cnt != 1) begin n_fail++; $display("FAIL gaps_valid run=%0d got=%b/%0d exp=1/1", k, bus.out_valid, ov_cnt); end
      n_checks++; if (bus.data_out !== 8'b11010011 || bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL gaps_result run=%0d got=%b/%b exp=11010011/000", k, bus.data_out, bus.syndrome); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sof   = (i == 0);
      bus.in_bit   = CW_CLEAN[CW_LEN-1-i];
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.data_out !== 8'h00 || bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL arst_result got=%b/%b exp=0/0", bus.data_out, bus.syndrome); end
    n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_err_cnt got=%0d exp=0", bus.err_cnt); end
    n_checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_handshake got=%b/%b exp=0/0", bus.in_ready, bus.out_valid); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    rst          = 1'b0;
    // Bits without sof in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
    end
    drive_frame(CW_CLEAN, 1'b0);
    n_checks++; if (ov_cnt != 1 || bus.syndrome !== 3'b000) begin n_fail++; $display("FAIL arst_recover got=%0d/%b exp=1/000", ov_cnt, bus.syndrome); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 254; f++) drive_frame(CW_ERR0, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_pre got=%0d exp=254", bus.err_cnt); end
    drive_frame(CW_ERR0, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_max got=%0d exp=255", bus.err_cnt); end
    for (int f = 0; f < 5; f++) drive_frame(CW_ERR0, 1'b0);
    @(negedge clk);
    n_checks++; if (bus.err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", bus.err_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_clean();
    test_errors();
    test_backpressure();
    test_abort();
    test_gaps();
    test_reset_midframe();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
